press_gen: RTL and testbench
============================

Name: press_gen

Overview:
- Generates clean button-style press/release waveforms from single-cycle trigger requests. It is the transmitting end of the press/release interface that the release detectors consume.
- Drives synth key inputs from sequencer and test logic. Every press is held for a programmable time and followed by a guaranteed low gap, so downstream release detection sees exactly one release per trigger.
- Requests that arrive while a press is in progress are queued in a small saturating counter.

Parameters:
HOLD_W, 8, width of hold_len input and hold counter
GAP_CYCLES, 2, cycles out is held low after each press; must be >= 1
MAX_PEND, 3, maximum queued requests; must be >= 1 and <= 2**PEND_W-1
PEND_W, 2, width of pend_cnt

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
trig  input  1  press request, one cycle per request; a multi-cycle high counts as one request per cycle
hold_len  input  HOLD_W  press duration in cycles; sampled when a press starts; 0 treated as 1
out  output  1  generated press level, registered
busy  output  1  high while state != IDLE, registered
pend_cnt  output  PEND_W  number of queued requests
overflow  output  1  one-cycle pulse: a request was dropped because the queue was full

Behaviour:
- State machine: IDLE, PRESS, GAP. out = (state == PRESS); busy = (state != IDLE). Both are decoded from registered state, so neither has a combinational path from inputs.
- Reset (reset = 0, asynchronous) forces these values immediately and holds them until reset returns to 1:
  - state = IDLE, out = 0, busy = 0, pend_cnt = 0, overflow = 0, counters = 0.
- Reset mid-press drops out to 0 at once and discards all queued requests. No gap is guaranteed in that case.
- IDLE:
  - trig = 1 at edge k -> PRESS after edge k.
  - Hold counter loads H = max(hold_len, 1).
  - Latency from trig to out rising is 1 cycle.
- PRESS:
  - out = 1 for exactly H cycles, i.e. after edges k .. k+H-1.
  - After edge k+H -> GAP, with the gap counter loaded to GAP_CYCLES.
- GAP:
  - out = 0 for exactly GAP_CYCLES cycles.
  - On the edge ending the last gap cycle:
    - If pend_cnt > 0 -> PRESS, pend_cnt decrements, hold_len is sampled on that edge.
    - Else if trig = 1 -> PRESS, trig is consumed directly, not queued.
    - Else -> IDLE.
- Queueing: trig = 1 while state is PRESS or GAP, and not consumed by a GAP->PRESS transition:
  - pend_cnt < MAX_PEND: pend_cnt increments.
  - pend_cnt == MAX_PEND: request dropped, overflow = 1 for the following cycle only.
- Simultaneous trig and pop on the GAP->PRESS edge with pend_cnt > 0: pend_cnt stays unchanged (one in, one out). If pend_cnt == MAX_PEND, no overflow is raised.
- Minimum trigger-to-trigger press period is H + GAP_CYCLES cycles. A queued press starts immediately after the gap, with no IDLE cycle between.
- hold_len may change at any time. Only the value on the press-start edge matters.
- The hold counter never wraps: the largest hold is 2**HOLD_W-1 cycles. A zero value is forced to 1.

Optional Feature:
- Macro: PRESS_GEN_DONE_EN.
- Defined: adds output port done (1 bit, reset 0). done is a one-cycle pulse in the cycle after the final GAP cycle of each press, meaning the release has been fully delivered. It pulses once per press, including back-to-back queued presses.
- Undefined: no done port and no done logic. All other behaviour is identical.

Test Plan:
- Basic press, hold_len = 3: release reset, trig pulse at edge 2 -> out high after edges 2,3,4; low from edge 5; busy high edges 2-6; IDLE after edge 7; pend_cnt stays 0.
- hold_len = 0: single trig -> out high for exactly 1 cycle, then 2 low gap cycles, then IDLE.
- Queue and back-to-back, hold_len = 2: trig at edges 0, 1, 2 -> pend_cnt 1 then 2; three presses, each high 2 cycles, separated by exactly 2 low cycles; busy continuous; pend_cnt returns to 0.
- Overflow, MAX_PEND = 3: trig held high 6 cycles during a long press (hold_len = 20) -> pend_cnt saturates at 3; overflow pulses once per dropped request (2 pulses); exactly 4 presses total.
- Simultaneous events: trig on the last GAP cycle with pend_cnt = 0 -> PRESS immediately and pend_cnt stays 0. Same with pend_cnt = 3 -> pend_cnt stays 3 and no overflow.
- Reset mid-press: assert reset between edges during PRESS with pend_cnt = 2 -> out, busy and pend_cnt go 0 immediately, without waiting for a clock edge. After release, a new trig produces a normal press. With PRESS_GEN_DONE_EN defined, done pulses after each completed gap and never for the aborted press.

Source files
------------

// File: rtl/press_gen.sv
// Press/release waveform generator: turns single-cycle trigger requests into
// held presses followed by a guaranteed low gap. Optional done pulse: PRESS_GEN_DONE_EN.
module press_gen #(
    parameter int HOLD_W     = 8,
    parameter int GAP_CYCLES = 2,
    parameter int MAX_PEND   = 3,
    parameter int PEND_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
`ifdef PRESS_GEN_DONE_EN
    ,
    output logic              done
`endif
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic              ovf_reg, ovf_next;
    logic [HOLD_W-1:0] hold_load;
    logic              gap_end;
    logic              pop;
    logic              consume;
    logic              push;

    // A zero hold request still yields a one-cycle press.
    assign hold_load = (hold_len == '0) ? HOLD_ONE : hold_len;
    assign gap_end   = (state_reg == GAP) && (gap_reg <= GAP_ONE);

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        gap_next   = gap_reg;
        pend_next  = pend_reg;
        ovf_next   = 1'b0;
        pop        = 1'b0;
        consume    = 1'b0;
        push       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (trig) begin
                    state_next = PRESS;
                    hold_next  = hold_load;
                    consume    = 1'b1;
                end
            end
            PRESS: begin
                if (hold_reg <= HOLD_ONE) begin
                    state_next = GAP;
                    gap_next   = GAP_LOAD;
                end else begin
                    hold_next = hold_reg - HOLD_ONE;
                end
            end
            GAP: begin
                if (gap_end) begin
                    // Queued requests take priority over a fresh trigger.
                    if (pend_reg != '0) begin
                        state_next = PRESS;
                        hold_next  = hold_load;
                        pop        = 1'b1;
                    end else if (trig) begin
                        state_next = PRESS;
                        hold_next  = hold_load;
                        consume    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_next = gap_reg - GAP_ONE;
                end
            end
            default: state_next = IDLE;
        endcase

        push = trig && !consume && (state_reg != IDLE);

        // A push coinciding with a pop frees its own slot, so it never overflows.
        if (push && pop) begin
            pend_next = pend_reg;
        end else if (push) begin
            if (pend_reg < PEND_MAX) begin
                pend_next = pend_reg + PEND_W'(1);
            end else begin
                ovf_next = 1'b1;
            end
        end else if (pop) begin
            pend_next = pend_reg - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
            gap_reg   <= '0;
            pend_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            gap_reg   <= gap_next;
            pend_reg  <= pend_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign out      = (state_reg == PRESS);
    assign busy     = (state_reg != IDLE);
    assign pend_cnt = pend_reg;
    assign overflow = ovf_reg;

`ifdef PRESS_GEN_DONE_EN
    logic done_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= gap_end;
        end
    end

    assign done = done_reg;
`endif

endmodule

// File: tb/tb_press_gen.sv
// Directed-vector bench for press_gen (default parameters: GAP_CYCLES=2, MAX_PEND=3).
module tb_press_gen;

    logic       clk;
    logic       reset;
    logic       trig;
    logic [7:0] hold_len;
    logic       out;
    logic       busy;
    logic [1:0] pend_cnt;
    logic       overflow;
`ifdef PRESS_GEN_DONE_EN
    logic       done;
`endif

    int n_cmp = 0;
    int n_err = 0;

    press_gen dut (
        .clk      (clk),
        .reset    (reset),
        .trig     (trig),
        .hold_len (hold_len),
        .out      (out),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
`ifdef PRESS_GEN_DONE_EN
        ,
        .done     (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eo, input logic eb,
                           input logic [1:0] ep, input logic ev, input logic ed);
        chk({tag, ".out"}, 32'(out), 32'(eo));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".pend"}, 32'(pend_cnt), 32'(ep));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ev));
`ifdef PRESS_GEN_DONE_EN
        chk({tag, ".done"}, 32'(done), 32'(ed));
`else
        if (ed === 1'bx) $display("note %s: undefined done expectation", tag);
`endif
    endtask

    // Apply inputs, take one clock edge, check outputs 1 time unit later.
    task automatic cyc(input string tag, input logic t, input logic [7:0] h,
                       input logic eo, input logic eb, input logic [1:0] ep,
                       input logic ev, input logic ed);
        trig     = t;
        hold_len = h;
        @(posedge clk);
        #1;
        $display("%0t %s trig=%0d hold=%0d out=%0d busy=%0d pend=%0d ovf=%0d",
                 $time, tag, t, h, out, busy, pend_cnt, overflow);
        chk_all(tag, eo, eb, ep, ev, ed);
    endtask

    // Let the generator run with trig low until idle; returns presses started.
    task automatic drain(input string tag, output int presses, output int ovfs);
        logic prev_out;
        prev_out = out;
        presses  = 0;
        ovfs     = 0;
        trig     = 1'b0;
        for (int i = 0; i < 300 && busy; i++) begin
            @(posedge clk);
            #1;
            if (out && !prev_out) presses++;
            if (overflow) ovfs++;
            prev_out = out;
        end
        $display("%0t %s drained presses=%0d busy=%0d pend=%0d", $time, tag, presses, busy, pend_cnt);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        chk({tag, ".pend"}, 32'(pend_cnt), 32'd0);
    endtask

    logic [1:0] ovf_pend_exp [6];
    logic       ovf_flag_exp [6];

    initial begin
        int np;
        int nv;
        int ovf_total;

        reset    = 1'b0;
        trig     = 1'b0;
        hold_len = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;

        cyc("idle0", 0, 3, 0, 0, 0, 0, 0);
        cyc("idle1", 0, 3, 0, 0, 0, 0, 0);

        // Basic press, hold 3
        cyc("b_p0", 1, 3, 1, 1, 0, 0, 0);
        cyc("b_p1", 0, 3, 1, 1, 0, 0, 0);
        cyc("b_p2", 0, 3, 1, 1, 0, 0, 0);
        cyc("b_g0", 0, 3, 0, 1, 0, 0, 0);
        cyc("b_g1", 0, 3, 0, 1, 0, 0, 0);
        cyc("b_id", 0, 3, 0, 0, 0, 0, 1);
        cyc("b_id2", 0, 3, 0, 0, 0, 0, 0);

        // Zero hold treated as one
        cyc("z_p0", 1, 0, 1, 1, 0, 0, 0);
        cyc("z_g0", 0, 0, 0, 1, 0, 0, 0);
        cyc("z_g1", 0, 0, 0, 1, 0, 0, 0);
        cyc("z_id", 0, 0, 0, 0, 0, 0, 1);
        cyc("z_id2", 0, 0, 0, 0, 0, 0, 0);

        // Queue and back-to-back, hold 2
        cyc("q_00", 1, 2, 1, 1, 0, 0, 0);
        cyc("q_01", 1, 2, 1, 1, 1, 0, 0);
        cyc("q_02", 1, 2, 0, 1, 2, 0, 0);
        cyc("q_03", 0, 2, 0, 1, 2, 0, 0);
        cyc("q_04", 0, 2, 1, 1, 1, 0, 1);
        cyc("q_05", 0, 2, 1, 1, 1, 0, 0);
        cyc("q_06", 0, 2, 0, 1, 1, 0, 0);
        cyc("q_07", 0, 2, 0, 1, 1, 0, 0);
        cyc("q_08", 0, 2, 1, 1, 0, 0, 1);
        cyc("q_09", 0, 2, 1, 1, 0, 0, 0);
        cyc("q_10", 0, 2, 0, 1, 0, 0, 0);
        cyc("q_11", 0, 2, 0, 1, 0, 0, 0);
        cyc("q_12", 0, 2, 0, 0, 0, 0, 1);
        cyc("q_13", 0, 2, 0, 0, 0, 0, 0);

        // Overflow: trig high 6 cycles during a 20-cycle press
        ovf_pend_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        ovf_flag_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ovf_total = 0;
        for (int i = 0; i < 6; i++) begin
            cyc($sformatf("o_%0d", i), 1, 20, 1, 1, ovf_pend_exp[i], ovf_flag_exp[i], 0);
            if (overflow) ovf_total++;
        end
        hold_len = 8'd1;
        drain("o_drain", np, nv);
        ovf_total += nv;
        chk("o_presses", 32'(np + 1), 32'd4);
        chk("o_ovf_pulses", 32'(ovf_total), 32'd2);
        cyc("o_id", 0, 1, 0, 0, 0, 0, 0);

        // Simultaneous trig on last gap cycle, pend 0 then pend 3
        cyc("s_00", 1, 1, 1, 1, 0, 0, 0);
        cyc("s_01", 0, 1, 0, 1, 0, 0, 0);
        cyc("s_02", 0, 1, 0, 1, 0, 0, 0);
        cyc("s_03", 1, 3, 1, 1, 0, 0, 1);
        cyc("s_04", 1, 3, 1, 1, 1, 0, 0);
        cyc("s_05", 1, 3, 1, 1, 2, 0, 0);
        cyc("s_06", 1, 3, 0, 1, 3, 0, 0);
        cyc("s_07", 0, 3, 0, 1, 3, 0, 0);
        cyc("s_08", 1, 3, 1, 1, 3, 0, 1);
        hold_len = 8'd1;
        drain("s_drain", np, nv);
        chk("s_presses", 32'(np), 32'd3);
        cyc("s_id", 0, 1, 0, 0, 0, 0, 0);

        // Reset mid-press with two queued requests
        cyc("r_00", 1, 10, 1, 1, 0, 0, 0);
        cyc("r_01", 1, 10, 1, 1, 1, 0, 0);
        cyc("r_02", 1, 10, 1, 1, 2, 0, 0);
        trig = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        $display("%0t r_async out=%0d busy=%0d pend=%0d", $time, out, busy, pend_cnt);
        chk_all("r_async", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("r_hold", 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc("r_id", 0, 2, 0, 0, 0, 0, 0);
        cyc("r_p0", 1, 2, 1, 1, 0, 0, 0);
        cyc("r_p1", 0, 2, 1, 1, 0, 0, 0);
        cyc("r_g0", 0, 2, 0, 1, 0, 0, 0);
        cyc("r_g1", 0, 2, 0, 1, 0, 0, 0);
        cyc("r_end", 0, 2, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
